// File: rtl/quad_encoder_counter.sv
//-----------------------------------------------------------------------------
// quad_encoder_counter
//
// Quadrature encoder front end. The raw A/B pins are synchronised and
// glitch-filtered, then decoded 4x into a wrap-around signed angle count
// for the rotation-speed stage.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   enc_a      encoder channel A (asynchronous)
//   enc_b      encoder channel B (asynchronous)
//   enc_z      encoder index channel (asynchronous, ENC_INDEX_EN builds only)
//   clear_cnt  synchronous angle clear
//   clear_err  synchronous error clear
//   angle      CNT_W-bit two's-complement position count
//   dir        direction of last valid step (1 = forward, 0 = reverse)
//   step       one-cycle pulse on every counted step
//   err        sticky illegal-transition flag
//
// Build option: define ENC_INDEX_EN to add enc_z; a filtered rising edge of
// the index zeroes the angle (below clear_cnt, above step counting).
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module quad_encoder_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
`ifdef ENC_INDEX_EN
  input  logic             enc_z,
`endif
  input  logic             clear_cnt,
  input  logic             clear_err,
  output logic [CNT_W-1:0] angle,
  output logic             dir,
  output logic             step,
  output logic             err
);

`ifdef ENC_INDEX_EN
  localparam int unsigned NCH = 3;
`else
  localparam int unsigned NCH = 2;
`endif
  localparam int unsigned INIT_LEN = SYNC_STAGES + FILTER_LEN;
  localparam int unsigned FC_W     = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned ST_W     = $clog2(INIT_LEN);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_LEN - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(INIT_LEN - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [ST_W-1:0]  st_cnt_q;

  // Channel vector: bit 0 = A, bit 1 = B, bit 2 = Z (index builds)
  logic [NCH-1:0]   pins;
  logic [NCH-1:0]   sync_q [SYNC_STAGES];
  logic [NCH-1:0]   sa;
  logic [NCH-1:0]   filt_q;
  logic [NCH-1:0]   prev_q;
  logic [FC_W-1:0]  fc_q [NCH];

  logic             fwd, rev, bad;
  logic [CNT_W-1:0] angle_q;

`ifdef ENC_INDEX_EN
  logic             idx_rise;
  assign pins = {enc_z, enc_b, enc_a};
`else
  assign pins = {enc_b, enc_a};
`endif

  assign sa    = sync_q[SYNC_STAGES-1];
  assign angle = angle_q;

  // Input synchroniser
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pins;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // State register and startup timer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_INIT;
      st_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) st_cnt_q <= st_cnt_q + ST_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (st_cnt_q == ST_LAST) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Glitch filter; during startup the filtered levels track the synchroniser
  // directly so a resting non-00 encoder is not seen as a transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= '0;
      prev_q <= '0;
      for (int unsigned c = 0; c < NCH; c++) fc_q[c] <= '0;
    end else begin
      prev_q <= filt_q;
      if (state_q == ST_INIT) begin
        filt_q <= sa;
        for (int unsigned c = 0; c < NCH; c++) fc_q[c] <= '0;
      end else begin
        for (int unsigned c = 0; c < NCH; c++) begin
          if (sa[c] == filt_q[c]) begin
            fc_q[c] <= '0;
          end else if (fc_q[c] == FC_LAST) begin
            filt_q[c] <= sa[c];
            fc_q[c]   <= '0;
          end else begin
            fc_q[c] <= fc_q[c] + FC_W'(1);
          end
        end
      end
    end
  end

  // 4x decode of {A,B}: prev -> cur
  always_comb begin
    fwd = 1'b0;
    rev = 1'b0;
    bad = 1'b0;
    if (state_q == ST_RUN) begin
      case ({prev_q[0], prev_q[1], filt_q[0], filt_q[1]})
        4'b0010, 4'b1011, 4'b1101, 4'b0100: fwd = 1'b1;
        4'b0001, 4'b0111, 4'b1110, 4'b1000: rev = 1'b1;
        4'b0011, 4'b1100, 4'b0110, 4'b1001: bad = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef ENC_INDEX_EN
  assign idx_rise = (state_q == ST_RUN) && filt_q[2] && !prev_q[2];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      angle_q <= '0;
      dir     <= 1'b0;
      step    <= 1'b0;
      err     <= 1'b0;
    end else begin
      step <= fwd | rev;
      if (fwd)      dir <= 1'b1;
      else if (rev) dir <= 1'b0;

      if (clear_cnt)     angle_q <= '0;
`ifdef ENC_INDEX_EN
      else if (idx_rise) angle_q <= '0;
`endif
      else if (fwd)      angle_q <= angle_q + CNT_W'(1);
      else if (rev)      angle_q <= angle_q - CNT_W'(1);

      if (bad)            err <= 1'b1;
      else if (clear_err) err <= 1'b0;
    end
  end

endmodule
